// File: rtl/uart_tx_arbiter.sv
// N-way requester arbiter feeding a single byte-wide UART transmitter, with timeout and sticky error.
// Define UART_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  input  logic                err_clr,
  output logic [7:0]          uart_din,
  output logic                uart_wr_en,
  input  logic                uart_wr_rdy,
  output logic                busy,
  output logic [2:0]          last_grant,
  output logic [15:0]         tx_count,
  output logic                err
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_d;
  logic [NREQ-1:0]     ack_d;
  logic [7:0]          uart_din_d;
  logic                uart_wr_en_d;
  logic                busy_d;
  logic [IDX_W-1:0]    last_grant_d;
  logic [15:0]         tx_count_d;
  logic                err_d;

  logic [IDX_W-1:0]    start_c;
  logic [NREQ-1:0]     rot_c;
  logic                found_c;
  logic [IDX_W-1:0]    winner_c;
  logic [7:0]          win_byte_c;
  logic                grant_c;
  logic                timeout_c;

  // Arbitration: rotate requests so the search start sits at bit 0, then pick the lowest set bit.
  always_comb begin
`ifdef UART_ARB_RR_EN
    start_c = (last_grant == IDX_LAST) ? '0 : last_grant + IDX_W'(1);
`else
    start_c = '0;
`endif
    rot_c    = NREQ'({req, req} >> start_c);
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_c && rot_c[i]) begin
        found_c  = 1'b1;
        winner_c = IDX_W'((32'(start_c) + i) % NREQ);
      end
    end
    win_byte_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == winner_c) win_byte_c = req_data[8*i +: 8];
    end
    grant_c = (state == IDLE) && found_c && uart_wr_rdy;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ack        <= '0;
      uart_din   <= '0;
      uart_wr_en <= 1'b0;
      busy       <= 1'b0;
      last_grant <= IDX_LAST;
      tx_count   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ack        <= ack_d;
      uart_din   <= uart_din_d;
      uart_wr_en <= uart_wr_en_d;
      busy       <= busy_d;
      last_grant <= last_grant_d;
      tx_count   <= tx_count_d;
      err        <= err_d;
    end
  end

  // Next state; successful UART handshake wins over a coincident timeout
  always_comb begin
    state_d   = state;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (grant_c) state_d = ISSUE;
      end
      ISSUE: begin
        if (!uart_wr_rdy) begin
          state_d = WAIT_DONE;
        end else if (cnt >= CNT_LAST) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (uart_wr_rdy) begin
          state_d = IDLE;
        end else if (cnt >= CNT_LAST) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the timeout counter
  always_comb begin
    ack_d        = '0;
    uart_din_d   = uart_din;
    uart_wr_en_d = (state_d == ISSUE);
    busy_d       = (state_d != IDLE);
    last_grant_d = last_grant;
    tx_count_d   = tx_count;
    err_d        = err;
    cnt_d        = cnt;

    if (grant_c) begin
      ack_d        = NREQ'(1) << winner_c;
      uart_din_d   = win_byte_c;
      last_grant_d = winner_c;
      cnt_d        = '0;
    end else if (state != IDLE) begin
      cnt_d = cnt + CNT_W'(1);
    end

    if ((state == WAIT_DONE) && uart_wr_rdy) tx_count_d = tx_count + 16'd1;

    if (timeout_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-level reference model and directed scenarios.
// Honors UART_ARB_RR_EN in the model so it matches whichever arbitration the DUT was built with.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     ack;
  logic                err_clr = 1'b0;
  logic [7:0]          uart_din;
  logic                uart_wr_en;
  logic                uart_wr_rdy = 1'b1;
  logic                busy;
  logic [2:0]          last_grant;
  logic [15:0]         tx_count;
  logic                err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .err_clr(err_clr), .uart_din(uart_din), .uart_wr_en(uart_wr_en),
    .uart_wr_rdy(uart_wr_rdy), .busy(busy), .last_grant(last_grant),
    .tx_count(tx_count), .err(err)
  );

  // Reference model: phase 0 = idle, 1 = strobing the UART, 2 = waiting for completion
  int              m_ph;
  int              m_elapsed;
  int              m_last;
  logic [7:0]      m_din;
  logic [15:0]     m_cnt;
  logic            m_err;
  logic [NREQ-1:0] m_ack;

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    int s;
`ifdef UART_ARB_RR_EN
    s = (last + 1) % NREQ;
`else
    s = 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (r[(s + k) % NREQ]) return (s + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_elapsed = 0; m_last = NREQ - 1;
    m_din = 8'h00; m_cnt = 16'h0000; m_err = 1'b0; m_ack = '0;
  endtask

  task automatic model_step();
    int  w;
    bit  tmo;
    tmo   = 1'b0;
    m_ack = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_ph == 0) begin
      w = pick(req, m_last);
      if (w >= 0 && uart_wr_rdy) begin
        m_ph = 1; m_elapsed = 0; m_last = w;
        m_din = req_data[8*w +: 8];
        m_ack[w] = 1'b1;
      end
    end else begin
      m_elapsed++;
      if (m_ph == 1 && !uart_wr_rdy) m_ph = 2;
      else if (m_ph == 2 && uart_wr_rdy) begin m_ph = 0; m_cnt = m_cnt + 16'd1; end
      else if (m_elapsed >= TIMEOUT) begin m_ph = 0; tmo = 1'b1; end
    end
    if (tmo) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ack",        32'(ack),        32'(m_ack));
    chk("uart_wr_en", 32'(uart_wr_en), 32'(m_ph == 1));
    chk("uart_din",   32'(uart_din),   32'(m_din));
    chk("busy",       32'(busy),       32'(m_ph != 0));
    chk("last_grant", 32'(last_grant), 32'(m_last));
    chk("tx_count",   32'(tx_count),   32'(m_cnt));
    chk("err",        32'(err),        32'(m_err));
  endtask

  // Model advances on every rising edge; outputs checked just after it
  always @(posedge clk) begin
    model_step();
    #1;
    compare_all();
  end

  always @(negedge rst_n) model_reset();

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output int w);
    int n;
    n = 0;
    w = -1;
    while (ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", 32'(|ack), 32'd1);
    for (int i = 0; i < NREQ; i++) if (ack[i]) w = i;
  endtask

  task automatic serve(output int w);
    int n;
    uart_wr_rdy = 1'b1;
    wait_ack(w);
    uart_wr_rdy = 1'b0;
    @(negedge clk);
    uart_wr_rdy = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("serve_idle", 32'(busy), 32'd0);
  endtask

  task automatic count_strobe(output int n);
    n = 0;
    while (uart_wr_en && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    int exp_w;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ack",        32'(ack),        32'h0);
    chk("rst_wr_en",      32'(uart_wr_en), 32'h0);
    chk("rst_din",        32'(uart_din),   32'h00);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_last_grant", 32'(last_grant), 32'd3);
    chk("rst_tx_count",   32'(tx_count),   32'h0);
    chk("rst_err",        32'(err),        32'h0);
    rst_n = 1'b1;

    // Single byte from requester 2
    req_data = 32'($urandom);
    req_data[23:16] = 8'h7D;
    req = 4'b0100;
    @(negedge clk);
    chk("one_ack",   32'(ack),        32'h4);
    chk("one_din",   32'(uart_din),   32'h7D);
    chk("one_wr_en", 32'(uart_wr_en), 32'h1);
    chk("one_grant", 32'(last_grant), 32'd2);
    @(negedge clk);
    chk("one_ack_pulse", 32'(ack),        32'h0);
    chk("one_wr_hold",   32'(uart_wr_en), 32'h1);
    @(negedge clk);
    chk("one_wr_hold2",  32'(uart_wr_en), 32'h1);
    chk("one_din_hold",  32'(uart_din),   32'h7D);
    uart_wr_rdy = 1'b0;
    req = '0;
    @(negedge clk);
    chk("one_wait_wr", 32'(uart_wr_en), 32'h0);
    chk("one_wait_busy", 32'(busy),     32'h1);
    uart_wr_rdy = 1'b1;
    @(negedge clk);
    chk("one_done_busy", 32'(busy),     32'h0);
    chk("one_tx_count",  32'(tx_count), 32'd1);

    // Eight bytes with all requesters active
    do_reset();
    req_data = 32'($urandom);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      serve(w);
`ifdef UART_ARB_RR_EN
      exp_w = i % 4;
`else
      exp_w = 0;
`endif
      chk("grant_order", 32'(w), 32'(exp_w));
    end
    req = '0;
    chk("eight_tx_count", 32'(tx_count), 32'd8);

    // UART never accepts: timeout after TIMEOUT strobe cycles
    do_reset();
    req = 4'b0001;
    uart_wr_rdy = 1'b1;
    wait_ack(w);
    count_strobe(n);
    req = '0;
    chk("tmo_strobe_cycles", 32'(n),        32'd15);
    chk("tmo_err",           32'(err),      32'h1);
    chk("tmo_busy",          32'(busy),     32'h0);
    chk("tmo_tx_count",      32'(tx_count), 32'h0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("tmo_err_clr", 32'(err), 32'h0);

    // Timeout while err_clr is held: set must win
    req = 4'b1000;
    err_clr = 1'b1;
    wait_ack(w);
    count_strobe(n);
    req = '0;
    chk("tmo_setclr_err", 32'(err), 32'h1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Reset in the completion-wait phase
    do_reset();
    req = 4'b0010;
    uart_wr_rdy = 1'b1;
    wait_ack(w);
    uart_wr_rdy = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wr_en", 32'(uart_wr_en), 32'h0);
    chk("mid_busy",  32'(busy),       32'h0);
    chk("mid_grant", 32'(last_grant), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    uart_wr_rdy = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    chk("mid_first_ack", 32'(ack), 32'h1);
    req = '0;
    @(negedge clk);
    chk("mid_ack_once", 32'(ack), 32'h0);
    uart_wr_rdy = 1'b0;
    @(negedge clk);
    uart_wr_rdy = 1'b1;
    @(negedge clk);
    chk("mid_tx_count", 32'(tx_count), 32'd1);

    // Byte counter wrap
    force dut.tx_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.tx_count;
    req = 4'b0001;
    serve(w);
    req = '0;
    chk("wrap_tx_count", 32'(tx_count), 32'h0);

    // Random traffic, with stretches of a stuck UART and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req      = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      req_data = 32'($urandom);
      if ((c % 500) < 60) uart_wr_rdy = 1'b1;
      else                uart_wr_rdy = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        compare_all();
      end else begin
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
